// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types and constants for the CIM command dispatcher
// Purpose: host op encoding, compute command layout, macro mode constants and geometry.
// Ports: none (package).
package cim_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_COMP = 2'b11
    } op_e;

    // Field order matches Compute_command {spec, mode, len, rs1, rs2, rd}
    typedef struct packed {
        logic       spec;
        logic [2:0] mode;
        logic [2:0] len;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [5:0] rd;
    } comp_cmd_t;

    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_MUL = 3'b111;
    localparam int         ROW_NUM  = 16;
    localparam int         COL_BIT  = 6;
    localparam int         CMD_W    = 32;

    function automatic op_e cmd_op(input logic [CMD_W-1:0] word);
        return op_e'(word[31:30]);
    endfunction

endpackage

// File: rtl/cim_cmd_dispatcher_if.sv
// rtl/cim_cmd_dispatcher_if.sv - host and macro signal bundle of the dispatcher
// Purpose: groups host command/read-data handshake, ExLdSt channel and Compute channel.
// Modports: slave = dispatcher view, master = host + macro environment view.
interface cim_cmd_dispatcher_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_word;
    logic        rdata_valid;
    logic [15:0] rdata;
    logic        busy;
    logic        ExLdSt_valid;
    logic [6:0]  ExLdSt_command;
    logic [15:0] ExLdSt_data_o;
    logic        ExLdSt_data_oe;
    logic [15:0] ExLdSt_data_i;
    logic        Compute_valid;
    logic        Compute_ready;
    logic [24:0] Compute_command;

    modport slave (
        input  cmd_valid, cmd_word, ExLdSt_data_i, Compute_ready,
        output cmd_ready, rdata_valid, rdata, busy,
               ExLdSt_valid, ExLdSt_command, ExLdSt_data_o, ExLdSt_data_oe,
               Compute_valid, Compute_command
    );

    modport master (
        output cmd_valid, cmd_word, ExLdSt_data_i, Compute_ready,
        input  cmd_ready, rdata_valid, rdata, busy,
               ExLdSt_valid, ExLdSt_command, ExLdSt_data_o, ExLdSt_data_oe,
               Compute_valid, Compute_command
    );
endinterface

// File: rtl/cim_cmd_fifo.sv
// rtl/cim_cmd_fifo.sv - synchronous command FIFO
// Purpose: in-order buffer of host command words; push and pop may coincide when full.
// Ports: clk, rst (async high), i_push/i_wdata, i_pop, o_rdata (head), o_full, o_empty.
module cim_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/cim_cmd_dispatcher.sv
// rtl/cim_cmd_dispatcher.sv - CIM host command issue stage (FIFO, ExLdSt issue, Compute FSM, read pipe)
// Purpose: buffers host command words and issues them in order to the ExLdSt and Compute channels,
//   returning read data to the host. One Compute outstanding at a time.
// Ports: clk, rst (async high); bus (cim_cmd_dispatcher_if.slave): cmd_valid/cmd_ready/cmd_word,
//   rdata_valid/rdata, busy, ExLdSt_valid/command/data_o/data_oe/data_i, Compute_valid/ready/command.
// Parameters: FIFO_DEPTH (power of 2, >=2), RD_LAT (1..3) issue-edge-to-sample-edge read latency.
// Configuration: CIM_DISP_OVERLAP_EN lets non-conflicting WR/RD issue while a Compute is outstanding;
//   undefined, every WR/RD waits for the Compute to complete.
module cim_cmd_dispatcher
    import cim_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cim_cmd_dispatcher_if.slave  bus
);
    typedef enum logic {C_IDLE, C_WAIT} cstate_e;

    cstate_e          r_state;
    cstate_e          w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_head;
    op_e              w_op;
    logic [5:0]       w_addr;
    comp_cmd_t        w_head_comp;
    comp_cmd_t        r_comp;
    logic             w_hazard;
    logic             w_issue_ex;
    logic             w_load_comp;
    logic             r_ex_valid;
    logic [6:0]       r_ex_cmd;
    logic [15:0]      r_ex_wdata;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic             r_rdata_valid;
    logic [15:0]      r_rdata;
    logic             w_unused;

    cim_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.cmd_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_op        = cmd_op(w_head);
    assign w_addr      = w_head[21:16];
    assign w_head_comp = w_head[24:0];
    assign w_unused    = ^w_head[29:25];

    // Ready also rises when the head leaves this cycle, allowing push+pop while full
    assign bus.cmd_ready = ~w_full | w_pop;
    assign w_push        = bus.cmd_valid & bus.cmd_ready;

    always_comb begin
        w_hazard = 1'b0;
        if (r_state == C_WAIT) begin
`ifdef CIM_DISP_OVERLAP_EN
            if (w_op == OP_WR) begin
                w_hazard = (w_addr == r_comp.rs1) | (w_addr == r_comp.rs2) | (w_addr == r_comp.rd);
            end else if (w_op == OP_RD) begin
                w_hazard = (w_addr == r_comp.rd);
            end
`else
            w_hazard = 1'b1;
`endif
        end
    end

    // Head decision; the hazard uses the registered state, so a stall clears the cycle after Compute_ready
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue_ex  = 1'b0;
        w_load_comp = 1'b0;
        if (!w_empty) begin
            case (w_op)
                OP_NOP: w_pop = 1'b1;
                OP_WR, OP_RD: begin
                    if (!w_hazard) begin
                        w_pop      = 1'b1;
                        w_issue_ex = 1'b1;
                    end
                end
                OP_COMP: begin
                    if (r_state == C_IDLE) begin
                        w_pop       = 1'b1;
                        w_load_comp = 1'b1;
                    end
                end
                default: w_pop = 1'b0;
            endcase
        end
        case (r_state)
            C_IDLE:  if (w_load_comp)       w_state_nxt = C_WAIT;
            C_WAIT:  if (bus.Compute_ready) w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= C_IDLE;
            r_comp        <= '0;
            r_ex_valid    <= 1'b0;
            r_ex_cmd      <= '0;
            r_ex_wdata    <= '0;
            r_rd_pipe     <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_valid <= w_issue_ex;
            r_ex_cmd   <= w_issue_ex ? {(w_op == OP_WR), w_addr} : 7'd0;
            r_ex_wdata <= (w_issue_ex && w_op == OP_WR) ? w_head[15:0] : 16'd0;
            if (w_load_comp) begin
                r_comp <= w_head_comp;
            end
            // Read tag shifts until the edge that samples the bus
            r_rd_pipe[0] <= w_issue_ex & (w_op == OP_RD);
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            r_rdata_valid <= r_rd_pipe[RD_LAT-1];
            if (r_rd_pipe[RD_LAT-1]) begin
                r_rdata <= bus.ExLdSt_data_i;
            end
        end
    end

    assign bus.ExLdSt_valid    = r_ex_valid;
    assign bus.ExLdSt_command  = r_ex_cmd;
    assign bus.ExLdSt_data_o   = r_ex_wdata;
    assign bus.ExLdSt_data_oe  = r_ex_valid & r_ex_cmd[6];
    assign bus.Compute_valid   = (r_state == C_WAIT);
    assign bus.Compute_command = r_comp;
    assign bus.rdata_valid     = r_rdata_valid;
    assign bus.rdata           = r_rdata;
    assign bus.busy            = ~w_empty | (r_state == C_WAIT) | (|r_rd_pipe);
endmodule
